// File: rtl/acumulador.sv
// Purpose : sums a block of n_samples unsigned samples and presents the total with its sample count.
// Latency : one cycle; out_valid is set by the edge that accepts the last sample of a block.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready consumes it.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     - sample handshake, in_data carries the sample
//   n_samples             - block length (0 means 2^CNT_W), taken on the first beat only
//   out_valid/out_ready   - result handshake, out_sum/out_count carry the result
module acumulador #(
   parameter int DATA_W = 44,
   parameter int CNT_W  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [CNT_W-1:0]        n_samples,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W+CNT_W-1:0] out_sum,
   output logic [CNT_W:0]          out_count
);

   localparam int ACC_W = DATA_W + CNT_W;
   localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] acc;
   logic [CNT_W:0]   cnt;
   logic [CNT_W:0]   target;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W:0]   first_target;
   logic             accept;
   logic             consume;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;
   assign cnt_inc = cnt + CNT_ONE;

   // A zero length encodes the largest block, which needs the extra counter bit.
   assign first_target = (n_samples == '0) ? CNT_MAX : {1'b0, n_samples};

   assign out_sum   = acc;
   assign out_count = cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake outputs decode the state register only, so there is no
   // combinational path from in_valid or out_ready to in_ready or out_valid.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               state_next = (first_target == CNT_ONE) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (accept && (cnt_inc == target)) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (consume) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Accumulator is DATA_W+CNT_W wide, enough for 2^CNT_W full-scale samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc    <= '0;
         cnt    <= '0;
         target <= '0;
      end else if (accept && (state == IDLE)) begin
         acc    <= {{CNT_W{1'b0}}, in_data};
         cnt    <= CNT_ONE;
         target <= first_target;
      end else if (accept && (state == ACCUM)) begin
         acc    <= acc + {{CNT_W{1'b0}}, in_data};
         cnt    <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_acumulador.sv
module tb_acumulador;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [43:0] in_data;
   logic [7:0]  n_samples;
   logic        out_valid;
   logic        out_ready;
   logic [51:0] out_sum;
   logic [8:0]  out_count;

   int errors;
   int checks;

   acumulador #(.DATA_W(44), .CNT_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .n_samples (n_samples),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; n_samples = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (out_sum !== 52'd0) begin errors++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      checks++; if (out_count !== 9'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
   endtask

   task automatic test_back_to_back();
      logic [43:0] vec [4];
      vec[0] = 44'd12; vec[1] = 44'd51; vec[2] = 44'd9; vec[3] = 44'd100;
      n_samples = 8'd4; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = vec[i];
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat %0d: got %0b expected 1", i, in_ready); end
         tick();
         if (i < 3) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid beat %0d: got %0b expected 0", i, out_valid); end
         end
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %0b expected 1", out_valid); end
      checks++; if (out_sum !== 52'd172) begin errors++; $display("FAIL b2b_out_sum: got %0d expected 172", out_sum); end
      checks++; if (out_count !== 9'd4) begin errors++; $display("FAIL b2b_out_count: got %0d expected 4", out_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_in_ready: got %0b expected 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %0b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_single_max();
      n_samples = 8'd1; out_ready = 1'b0; in_valid = 1'b1; in_data = 44'hFFF_FFFF_FFFF;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid cyc %0d: got %0b expected 1", i, out_valid); end
         checks++; if (out_sum !== 52'd17592186044415) begin errors++; $display("FAIL single_out_sum cyc %0d: got %0d expected 17592186044415", i, out_sum); end
         checks++; if (out_count !== 9'd1) begin errors++; $display("FAIL single_out_count cyc %0d: got %0d expected 1", i, out_count); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready cyc %0d: got %0b expected 0", i, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %0b expected 0", out_valid); end
   endtask

   task automatic test_full_block();
      n_samples = 8'd0; out_ready = 1'b0; in_valid = 1'b1; in_data = 44'hFFF_FFFF_FFFF;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %0b expected 0", out_valid); end
         end
         tick();
         // Length changes after the first beat must not shorten the block.
         if (i == 0) n_samples = 8'd2;
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %0b expected 1", out_valid); end
      checks++; if (out_sum !== 52'hF_FFFF_FFFF_FF00) begin errors++; $display("FAIL full_out_sum: got %0h expected fffffffffff00", out_sum); end
      checks++; if (out_count !== 9'd256) begin errors++; $display("FAIL full_out_count: got %0d expected 256", out_count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_consumed: got %0b expected 0", out_valid); end
   endtask

   task automatic test_bubbles();
      logic        vld [6];
      logic [43:0] dat [6];
      vld[0] = 1; dat[0] = 44'd5;
      vld[1] = 0; dat[1] = 44'd999;
      vld[2] = 0; dat[2] = 44'd888;
      vld[3] = 1; dat[3] = 44'd1000;
      vld[4] = 0; dat[4] = 44'd777;
      vld[5] = 1; dat[5] = 44'd77;
      n_samples = 8'd3; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = vld[i]; in_data = dat[i];
         tick();
      end
      // Keep offering a sample while held; it must not be taken.
      in_valid = 1'b1; in_data = 44'd123;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bub_out_valid cyc %0d: got %0b expected 1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bub_in_ready cyc %0d: got %0b expected 0", i, in_ready); end
         checks++; if (out_sum !== 52'd1082) begin errors++; $display("FAIL bub_out_sum cyc %0d: got %0d expected 1082", i, out_sum); end
         checks++; if (out_count !== 9'd3) begin errors++; $display("FAIL bub_out_count cyc %0d: got %0d expected 3", i, out_count); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_consumed: got %0b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_idle_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_reset_mid_block();
      n_samples = 8'd5; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 44'd40; tick();
      in_data = 44'd50; tick();
      in_valid = 1'b0; reset = 1'b1; tick();
      reset = 1'b0;
      checks++; if (out_count !== 9'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", out_count); end
      checks++; if (out_sum !== 52'd0) begin errors++; $display("FAIL rst_mid_sum: got %0d expected 0", out_sum); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid cyc %0d: got %0b expected 0", i, out_valid); end
         tick();
      end
      n_samples = 8'd2; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 44'd7; tick();
      in_data = 44'd8; tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_next_valid: got %0b expected 1", out_valid); end
      checks++; if (out_sum !== 52'd15) begin errors++; $display("FAIL rst_next_sum: got %0d expected 15", out_sum); end
      checks++; if (out_count !== 9'd2) begin errors++; $display("FAIL rst_next_count: got %0d expected 2", out_count); end
      // Reset wins over a simultaneous consume in HOLD.
      reset = 1'b1; out_ready = 1'b1; tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %0b expected 0", out_valid); end
      checks++; if (out_sum !== 52'd0) begin errors++; $display("FAIL rst_hold_sum: got %0d expected 0", out_sum); end
      // Reset wins over a simultaneous accept in IDLE.
      in_valid = 1'b1; in_data = 44'd9; n_samples = 8'd1; tick();
      reset = 1'b0; in_valid = 1'b0;
      checks++; if (out_count !== 9'd0) begin errors++; $display("FAIL rst_accept_count: got %0d expected 0", out_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_accept_in_ready: got %0b expected 1", in_ready); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_back_to_back();
      test_single_max();
      test_full_block();
      test_bubbles();
      test_reset_mid_block();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acumulador.md
ACUMULADOR -- requirements
Module: acumulador

Interface
REQ-001 Parameter DATA_W, default 44, SHALL set the width of each incoming sum sample.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the block-length field and sample counter.
REQ-003 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, SHALL flag that in_data holds a valid sample.
REQ-006 Port in_ready, output, 1, SHALL flag that the block accepts a sample this cycle.
REQ-007 Port in_data, input, DATA_W, SHALL be the unsigned sample from the registered adder output.
REQ-008 Port n_samples, input, CNT_W, SHALL give the block length, sampled only on the first beat of a block.
REQ-009 Port out_valid, output, 1, SHALL flag that out_sum and out_count are valid.
REQ-010 Port out_ready, input, 1, SHALL flag that the consumer takes the result this cycle.
REQ-011 Port out_sum, output, DATA_W+CNT_W, SHALL carry the accumulated block total.
REQ-012 Port out_count, output, CNT_W+1, SHALL carry the number of samples summed into out_sum.

Function
REQ-013 Accept beat SHALL occur on a rising edge where in_valid and in_ready are both 1; consume beat likewise with out_valid and out_ready.
REQ-014 FSM SHALL have three states: IDLE, ACCUM, HOLD.
REQ-015 IDLE: in_ready=1, out_valid=0; on accept, acc <= zero-extended in_data, cnt <= 1, target <= n_samples (0 means 2^CNT_W); go to HOLD if target==1, else ACCUM.
REQ-016 ACCUM: in_ready=1, out_valid=0; on accept, acc <= acc + in_data, cnt <= cnt+1; go to HOLD when the new cnt equals target; no accept means hold all state.
REQ-017 HOLD: in_ready=0, out_valid=1, out_sum=acc, out_count=cnt held stable until consume beat; on consume go to IDLE.
REQ-018 Latency SHALL be one cycle: out_valid rises on the edge that accepts the final sample of a block.
REQ-019 Accumulator width DATA_W+CNT_W SHALL make overflow impossible; no truncation or saturation.
REQ-020 n_samples changes after the first beat of a block SHALL have no effect on that block.
REQ-021 in_valid gaps (bubbles) within a block SHALL be tolerated without losing or duplicating samples.
REQ-022 in_ready and out_valid SHALL be pure functions of the FSM state (registered, no combinational path from in_valid/out_ready).
REQ-023 After a consume beat, a new block SHALL be accepted no earlier than the following cycle (HOLD -> IDLE).

Reset
REQ-024 reset=1 SHALL force state IDLE, acc=0, cnt=0, target=0, out_valid=0, in_ready=1 (IDLE value), out_sum=0, out_count=0 at the next rising edge.
REQ-025 reset asserted mid-block or in HOLD SHALL discard the partial or pending result; reset SHALL dominate simultaneous accept or consume beats.

Verification
REQ-026 n_samples=4, in_data 12,51,9,100 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=172, out_count=4, then IDLE.
REQ-027 n_samples=1, in_data=2^44-1 -> out_sum=17592186044415, out_count=1, in_ready=0 while in HOLD.
REQ-028 n_samples=0, 256 beats of 2^44-1 -> out_sum=256*(2^44-1), out_count=256, no overflow.
REQ-029 n_samples=3, in_valid toggled with bubbles, out_ready=0 for 5 cycles in HOLD -> in_ready=0, out_sum=sum of 3 samples stable throughout, consumed on out_ready=1.
REQ-030 n_samples=5, reset pulsed after 2nd accept -> out_valid never rises; next block of 2 samples (7,8, n_samples=2) yields out_sum=15.
